// File: rtl/synth_pkg.sv
// Shared types and constants for the voice bank: waveform select, sequencer
// states and gain format.
package synth_pkg;

  localparam int GAIN_WIDTH = 16;
  localparam logic [GAIN_WIDTH-1:0] GAIN_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    WAVE_SAW     = 2'd0,
    WAVE_SQUARE  = 2'd1,
    WAVE_TRI     = 2'd2,
    WAVE_SILENCE = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SCALE = 2'd2
  } state_t;

endpackage

// File: rtl/wave_gen.sv
// Combinational oscillator shaper: 32-bit phase plus waveform select to a
// signed sample. Shared by all voices through time multiplexing.
module wave_gen
  import synth_pkg::*;
#(
  parameter int AUDIO_WIDTH = 32
) (
  input  logic [31:0]                   phase,
  input  wave_t                         wave_type,
  output logic signed [AUDIO_WIDTH-1:0] sample
);

  localparam int AW = AUDIO_WIDTH;
  localparam logic signed [AW-1:0] PEAK = {1'b0, {(AW-1){1'b1}}};

  logic [AW-1:0] p_top;
  logic [31:0]   p_shl;
  logic [AW-1:0] fold;

  assign p_top = phase[31 -: AW];
  assign p_shl = {phase[30:0], 1'b0};
  // second half of the cycle mirrors the first to form the falling ramp
  assign fold  = phase[31] ? ~p_shl[31 -: AW] : p_shl[31 -: AW];

  always_comb begin
    sample = '0;
    case (wave_type)
      WAVE_SAW:    sample = {~p_top[AW-1], p_top[AW-2:0]};
      WAVE_SQUARE: sample = phase[31] ? -PEAK : PEAK;
      WAVE_TRI:    sample = {~fold[AW-1], fold[AW-2:0]};
      default:     sample = '0;
    endcase
  end

endmodule

// File: rtl/voice_bank.sv
// Time-multiplexed NUM_VOICES oscillator bank with per-voice AR gain and mixer.
// Optional octave-doubling oscillators are built when SYNTH_OCTAVE_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for sample_tick, inputs captured on the tick
// ST_RUN   | one voice per cycle: advance phase, gain, accumulate
// ST_SCALE | mix_out presented, mix_valid high for this cycle
module voice_bank
  import synth_pkg::*;
#(
  parameter int                    NUM_VOICES   = 8,
  parameter int                    AUDIO_WIDTH  = 32,
  parameter logic [GAIN_WIDTH-1:0] ATTACK_STEP  = 16'h0100,
  parameter logic [GAIN_WIDTH-1:0] RELEASE_STEP = 16'h0080
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic [NUM_VOICES-1:0]         voice_on,
  input  logic [NUM_VOICES*32-1:0]      phase_incr,
  input  logic [1:0]                    wave_type,
  input  logic                          octave_on,
  output logic signed [AUDIO_WIDTH-1:0] mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int AW    = AUDIO_WIDTH;
  localparam int IW    = $clog2(NUM_VOICES);
  localparam int ACC_W = AW + IW;
  localparam int PW    = AW + GAIN_WIDTH + 1;

  state_t state, state_nxt;
  logic [IW-1:0]         idx;
  logic                  last;
  logic [NUM_VOICES-1:0] gate_cap, gate_prev;
  logic [31:0]           incr_cap [NUM_VOICES];
  wave_t                 wave_cap;
  logic [31:0]           phase [NUM_VOICES];
  logic [GAIN_WIDTH-1:0] gain  [NUM_VOICES];
  logic signed [ACC_W-1:0] acc, acc_sum, contrib;

  logic                  rise;
  logic [31:0]           incr_cur, phase_nxt;
  logic [GAIN_WIDTH-1:0] gain_cur, gain_nxt;
  logic signed [AW-1:0]  wave_base, wave;
  logic signed [PW-1:0]  wave_ext, gain_ext, prod;

  assign last      = (idx == IW'(NUM_VOICES - 1));
  assign incr_cur  = incr_cap[idx];
  // a gate that rose since the previous accepted tick restarts its oscillator
  assign rise      = gate_cap[idx] & ~gate_prev[idx];
  assign phase_nxt = (rise ? 32'd0 : phase[idx]) + incr_cur;

  always_comb begin
    gain_cur = gain[idx];
    gain_nxt = gain_cur;
    if (gate_cap[idx])
      gain_nxt = (gain_cur > GAIN_MAX - ATTACK_STEP) ? GAIN_MAX : gain_cur + ATTACK_STEP;
    else
      gain_nxt = (gain_cur < RELEASE_STEP) ? '0 : gain_cur - RELEASE_STEP;
  end

  wave_gen #(.AUDIO_WIDTH(AW)) u_wave (
    .phase     (phase_nxt),
    .wave_type (wave_cap),
    .sample    (wave_base)
  );

`ifdef SYNTH_OCTAVE_EN
  logic [31:0]          oct [NUM_VOICES];
  logic                 oct_cap;
  logic [31:0]          oct_nxt;
  logic signed [AW-1:0] wave_oct;
  logic signed [AW:0]   wave_sum;

  assign oct_nxt  = (rise ? 32'd0 : oct[idx]) + (incr_cur << 1);
  assign wave_sum = (AW+1)'(wave_base) + (AW+1)'(wave_oct);
  assign wave     = oct_cap ? wave_sum[AW:1] : wave_base;

  wave_gen #(.AUDIO_WIDTH(AW)) u_wave_oct (
    .phase     (oct_nxt),
    .wave_type (wave_cap),
    .sample    (wave_oct)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      oct_cap <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) oct[i] <= '0;
    end else begin
      if (state == ST_IDLE && sample_tick) oct_cap <= octave_on;
      if (state == ST_RUN) oct[idx] <= oct_nxt;
    end
  end
`else
  logic unused_octave;
  assign unused_octave = octave_on;
  assign wave          = wave_base;
`endif

  assign wave_ext = PW'(wave);
  assign gain_ext = PW'({1'b0, gain_nxt});
  assign prod     = wave_ext * gain_ext;
  assign contrib  = ACC_W'(prod >>> GAIN_WIDTH);
  assign acc_sum  = acc + contrib;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (sample_tick) state_nxt = ST_RUN;
      ST_RUN:   if (last) state_nxt = ST_SCALE;
      ST_SCALE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign mix_valid = (state == ST_SCALE);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      gate_cap  <= '0;
      gate_prev <= '0;
      wave_cap  <= WAVE_SAW;
      acc       <= '0;
      mix_out   <= '0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        incr_cap[i] <= '0;
        phase[i]    <= '0;
        gain[i]     <= '0;
      end
    end else begin
      if (sample_tick && state != ST_IDLE) overrun <= 1'b1;
      if (state == ST_IDLE && sample_tick) begin
        gate_prev <= gate_cap;
        gate_cap  <= voice_on;
        wave_cap  <= wave_t'(wave_type);
        idx       <= '0;
        acc       <= '0;
        for (int i = 0; i < NUM_VOICES; i++) incr_cap[i] <= phase_incr[32*i +: 32];
      end
      if (state == ST_RUN) begin
        phase[idx] <= phase_nxt;
        gain[idx]  <= gain_nxt;
        acc        <= acc_sum;
        idx        <= idx + IW'(1);
        if (last) mix_out <= AW'(acc_sum >>> IW);
      end
    end
  end

endmodule

// File: tb/tb_voice_bank.sv
// Scoreboard bench for voice_bank: arithmetic reference model predicts each mix
// and its due cycle; a monitor pops and compares on every mix_valid.
module tb_voice_bank;

  localparam int NV = 8;
  localparam int AW = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_tick = 1'b0;
  logic [NV-1:0]        voice_on = '0;
  logic [NV*32-1:0]     phase_incr = '0;
  logic [1:0]           wave_type = 2'd0;
  logic                 octave_on = 1'b0;
  logic signed [AW-1:0] mix_out;
  logic                 mix_valid, busy, overrun;

  voice_bank #(.NUM_VOICES(NV), .AUDIO_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .voice_on    (voice_on),
    .phase_incr  (phase_incr),
    .wave_type   (wave_type),
    .octave_on   (octave_on),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint mix; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;

  bit [31:0] m_phase [NV];
  bit [31:0] m_oct   [NV];
  int        m_gain  [NV];
  bit [NV-1:0] m_prev = '0;
  int        last_acc = -100;
  bit        ovr_exp = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint wave_val(input bit [31:0] p, input int wt);
    longint pl, r;
    pl = longint'(p);
    case (wt)
      0: return pl - 64'sd2147483648;
      1: return (pl >= 64'sd2147483648) ? -64'sd2147483647 : 64'sd2147483647;
      2: begin
        r = (pl * 2) % 64'sd4294967296;
        if (pl >= 64'sd2147483648) r = 64'sd4294967295 - r;
        return r - 64'sd2147483648;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_phase[i] = '0;
      m_oct[i]   = '0;
      m_gain[i]  = 0;
    end
    m_prev   = '0;
    last_acc = -100;
    ovr_exp  = 1'b0;
  endtask

  // Called in the tick cycle with the inputs the DUT will capture.
  task automatic model_tick();
    longint sum, w;
    bit [31:0] inc;
    if (cyc - last_acc < NV + 2) begin
      ovr_exp = 1'b1;
      return;
    end
    last_acc = cyc;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      inc = phase_incr[32*i +: 32];
      if (voice_on[i] && !m_prev[i]) begin
        m_phase[i] = '0;
        m_oct[i]   = '0;
      end
      m_phase[i] = m_phase[i] + inc;
      m_oct[i]   = m_oct[i] + (inc << 1);
      if (voice_on[i]) m_gain[i] = (m_gain[i] + 256 > 65535) ? 65535 : m_gain[i] + 256;
      else             m_gain[i] = (m_gain[i] < 128) ? 0 : m_gain[i] - 128;
      w = wave_val(m_phase[i], int'(wave_type));
`ifdef SYNTH_OCTAVE_EN
      if (octave_on) w = (w + wave_val(m_oct[i], int'(wave_type))) >>> 1;
`endif
      sum += (w * longint'(m_gain[i])) >>> 16;
    end
    m_prev = voice_on;
    sb.push_back('{sum >>> 3, cyc + NV + 1});
  endtask

  always @(negedge clk) begin
    if (!rst && mix_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("mix_out", mix_out, mon_e.mix);
        check("valid_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int gap);
    cycle();
    sample_tick = 1'b1;
    model_tick();
    cycle();
    sample_tick = 1'b0;
    repeat (gap - 1) cycle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("rst_mix_out", mix_out, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // single square voice ramping to full gain
    voice_on   = 8'h01;
    phase_incr = '0;
    phase_incr[31:0] = 32'h0100_0000;
    wave_type  = 2'd1;
    for (int k = 0; k < 300; k++) tick(11);
    check("steady_peak", mix_out, ((64'sd2147483647 * 65535) >>> 16) >>> 3);

    // release from full gain
    voice_on = '0;
    for (int k = 0; k < 520; k++) tick(11);
    check("released_zero", mix_out, 0);
    check("no_overrun_yet", overrun, ovr_exp);

    // tick arriving while busy
    voice_on = 8'hA5;
    for (int i = 0; i < NV; i++) phase_incr[32*i +: 32] = $urandom;
    wave_type = 2'd0;
    tick(2);
    tick(11);
    check("overrun_set", overrun, ovr_exp);
    check("idle_busy", busy, 0);

    // full-scale increment wraps every tick
    voice_on   = 8'h01;
    phase_incr = '0;
    phase_incr[31:0] = 32'hFFFF_FFFF;
    wave_type  = 2'd0;
    for (int k = 0; k < 6; k++) tick(11);

    // randomized gates, increments, waves, spacing and octave toggling
    for (int k = 0; k < 80; k++) begin
      voice_on = NV'($urandom);
      for (int i = 0; i < NV; i++)
        phase_incr[32*i +: 32] = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1 << 26));
      wave_type = 2'($urandom_range(0, 3));
      octave_on = 1'($urandom);
      tick($urandom_range(1, 12));
    end
    drain();
    check("overrun_sticky", overrun, ovr_exp);

    // reset in the middle of a computation
    voice_on = '1;
    for (int i = 0; i < NV; i++) phase_incr[32*i +: 32] = $urandom;
    wave_type = 2'd2;
    tick(3);
    rst = 1'b1;
    if (sb.size() != 0) void'(sb.pop_back());
    model_reset();
    cycle();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", mix_valid, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_mix_out", mix_out, 0);
    repeat (12) cycle();

    voice_on   = 8'h03;
    phase_incr = '0;
    phase_incr[31:0]  = 32'h1000_0000;
    phase_incr[63:32] = 32'h0300_0000;
    wave_type  = 2'd0;
    for (int k = 0; k < 4; k++) tick(11);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
